// File: rtl/cpu_pkg.sv
// Shared integer-core constants and the register-file sweep state encoding.
// Combinational only: no latency and no backpressure.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 2 ** REG_AW;

    localparam logic [REG_AW-1:0] X0_IDX   = '0;
    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NREG - 1);
    localparam logic [REG_AW-1:0] FIRST_IDX = REG_AW'(1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset sweep sequencer: walks x1..x31 one entry per cycle, then goes READY.
// The sweep takes 31 cycles after reset drops; busy_o is the stall for the whole pipeline.
module regfile_clear_seq
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              busy_o,
    output logic              clear_en_o,
    output logic [REG_AW-1:0] clear_addr_o
);

    rf_state_e         state_q, state_d;
    logic [REG_AW-1:0] idx_q, idx_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        busy_o       = (state_q == CLEAR);
        clear_en_o   = 1'b0;
        clear_addr_o = idx_q;

        if (state_q == CLEAR) begin
            // While reset is held the index stays parked and nothing is written.
            clear_en_o = !rst_i;
            idx_d      = idx_q + REG_AW'(1);
            if (idx_q == LAST_IDX) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            idx_q   <= FIRST_IDX;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back select plus 32x32 integer register file with a post-reset clear sweep.
// Reads are combinational; commits land on the clock edge; busy_o stalls upstream. Macro REGFILE_BYPASS_EN enables write-first reads.
module wb_regfile
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [XLEN-1:0]   ALUResult_i,
    input  logic [XLEN-1:0]   RDdata_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    input  logic [REG_AW-1:0] RS1addr_i,
    input  logic [REG_AW-1:0] RS2addr_i,
    output logic [XLEN-1:0]   RS1data_o,
    output logic [XLEN-1:0]   RS2data_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              busy_o,
    output logic [31:0]       retire_cnt_o
);

    logic [XLEN-1:0]   mem_q [NREG];
    logic [31:0]       retire_cnt_q, retire_cnt_d;

    logic              busy;
    logic              clear_en;
    logic [REG_AW-1:0] clear_addr;

    logic              commit_vld;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [XLEN-1:0]   wr_dat;

    regfile_clear_seq u_clear_seq (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .busy_o       (busy),
        .clear_en_o   (clear_en),
        .clear_addr_o (clear_addr)
    );

    assign wb_data_o = MemtoReg_i ? RDdata_i : ALUResult_i;
    assign busy_o    = busy;

    // Writes arriving while busy are protocol violations and are silently dropped.
    assign commit_vld = !busy && !rst_i && RegWrite_i && (RDaddr_i != X0_IDX);

    always_comb begin
        wr_en   = clear_en || commit_vld;
        wr_addr = RDaddr_i;
        wr_dat  = wb_data_o;
        if (clear_en) begin
            wr_addr = clear_addr;
            wr_dat  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (commit_vld) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt_o = retire_cnt_q;

    function automatic logic [XLEN-1:0] read_port(input logic [REG_AW-1:0] addr);
        logic [XLEN-1:0] dat;
        dat = mem_q[addr];
        if (busy || addr == X0_IDX) begin
            dat = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (RegWrite_i && RDaddr_i != X0_IDX && RDaddr_i == addr) begin
            dat = wb_data_o;
        end
`endif
        return dat;
    endfunction

    assign RS1data_o = read_port(RS1addr_i);
    assign RS2data_o = read_port(RS2addr_i);

endmodule
